// File: rtl/avmm_pio_edge_irq_pkg.sv
// Shared constants for the Avalon-MM PIO with debounced edge-capture interrupts.
package avmm_pio_edge_irq_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    REG_IN       = 3'd0,
    REG_OUT      = 3'd1,
    REG_IRQ_MASK = 3'd2,
    REG_EDGE_CAP = 3'd3,
    REG_RISE_EN  = 3'd4,
    REG_FALL_EN  = 3'd5
  } reg_addr_e;

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: 2-flop synchronizer, debounce counter and accepted-edge pulses.
module pio_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;
  logic          accept;

  // The DEBOUNCE_CYCLES-th consecutive mismatching cycle commits the new level.
  assign accept = (sync_b != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise   = accept && sync_b;
  assign fall   = accept && !sync_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= pin;
      sync_b <= sync_a;
      if (sync_b == stable) begin
        cnt <= '0;
      end else if (accept) begin
        cnt    <= '0;
        stable <= sync_b;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/avmm_pio_edge_irq.sv
// Avalon-MM PIO: debounced inputs, registered outputs, edge capture and level irq.
module avmm_pio_edge_irq
  import avmm_pio_edge_irq_pkg::*;
#(
  parameter int unsigned NUM_CH          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [NUM_CH-1:0] pio_in,
  output logic [NUM_CH-1:0] pio_out,
  output logic              irq
);

  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] irq_mask;
  logic [NUM_CH-1:0] edge_cap;
  logic [NUM_CH-1:0] rise_en;
  logic [NUM_CH-1:0] fall_en;
  logic [NUM_CH-1:0] wdata;
  logic [NUM_CH-1:0] cap_clr;
  logic [DATA_W-1:0] rd_mux;
  logic              wr_out;
  logic              wr_mask;
  logic              wr_cap;
  logic              wr_rise;
  logic              wr_fall;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pio_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .pin   (pio_in[i]),
      .stable(stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  if (NUM_CH < DATA_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^avs_writedata[DATA_W-1:NUM_CH];
  end

  assign wdata   = avs_writedata[NUM_CH-1:0];
  assign wr_out  = avs_write && (avs_address == REG_OUT);
  assign wr_mask = avs_write && (avs_address == REG_IRQ_MASK);
  assign wr_cap  = avs_write && (avs_address == REG_EDGE_CAP);
  assign wr_rise = avs_write && (avs_address == REG_RISE_EN);
  assign wr_fall = avs_write && (avs_address == REG_FALL_EN);
  assign cap_clr = wr_cap ? wdata : '0;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      REG_IN:       rd_mux[NUM_CH-1:0] = stable;
      REG_OUT:      rd_mux[NUM_CH-1:0] = pio_out;
      REG_IRQ_MASK: rd_mux[NUM_CH-1:0] = irq_mask;
      REG_EDGE_CAP: rd_mux[NUM_CH-1:0] = edge_cap;
      REG_RISE_EN:  rd_mux[NUM_CH-1:0] = rise_en;
      REG_FALL_EN:  rd_mux[NUM_CH-1:0] = fall_en;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pio_out           <= '0;
      irq_mask          <= '0;
      edge_cap          <= '0;
      rise_en           <= '0;
      fall_en           <= '0;
      irq               <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      if (wr_out)  pio_out  <= wdata;
      if (wr_mask) irq_mask <= wdata;
      if (wr_rise) rise_en  <= wdata;
      if (wr_fall) fall_en  <= wdata;
      // Set terms are OR-ed after the clear so a coincident new edge survives.
      edge_cap          <= (edge_cap & ~cap_clr) | (rise & rise_en) | (fall & fall_en);
      irq               <= |(edge_cap & irq_mask);
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_avmm_pio_edge_irq.sv
// Randomized and directed bench for avmm_pio_edge_irq against a window-based reference model.
module tb_avmm_pio_edge_irq;

  localparam int NCH = 8;
  localparam int DB  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [7:0]  pio_in;
  logic [7:0]  pio_out;
  logic        irq;

  always #5 clk = ~clk;

  avmm_pio_edge_irq #(
    .NUM_CH(NCH),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .pio_in           (pio_in),
    .pio_out          (pio_out),
    .irq              (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state; hist[k] is the pin sample taken k edges ago.
  logic [7:0]  m_out, m_mask, m_cap, m_rise, m_fall, m_stable;
  logic        m_irq, m_rvalid;
  logic [31:0] m_rdata;
  logic [7:0]  hist [0:DB];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] m_reg(input logic [2:0] a);
    logic [7:0] v;
    case (a)
      3'd0: v = m_stable;
      3'd1: v = m_out;
      3'd2: v = m_mask;
      3'd3: v = m_cap;
      3'd4: v = m_rise;
      3'd5: v = m_fall;
      default: v = 8'h00;
    endcase
    return {24'h0, v};
  endfunction

  // A level is accepted once the synchronized pin has shown it for DB
  // consecutive cycles, i.e. pin samples 2..DB+1 edges old all differ from stable.
  task automatic model_edge();
    logic [7:0] nstable, rise_ev, fall_ev, ncap;
    logic       all_diff;
    if (reset) begin
      m_out = '0; m_mask = '0; m_cap = '0; m_rise = '0; m_fall = '0; m_stable = '0;
      m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      for (int k = 0; k <= DB; k++) hist[k] = '0;
    end else begin
      nstable = m_stable;
      for (int b = 0; b < NCH; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DB; k++) if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) nstable[b] = ~m_stable[b];
      end
      rise_ev = nstable & ~m_stable;
      fall_ev = ~nstable & m_stable;
      m_rvalid = avs_read;
      if (avs_read) m_rdata = m_reg(avs_address);
      ncap = m_cap;
      if (avs_write && avs_address == 3'd3) ncap = ncap & ~avs_writedata[7:0];
      ncap = ncap | (rise_ev & m_rise) | (fall_ev & m_fall);
      m_irq = |(m_cap & m_mask);
      if (avs_write && avs_address == 3'd1) m_out  = avs_writedata[7:0];
      if (avs_write && avs_address == 3'd2) m_mask = avs_writedata[7:0];
      if (avs_write && avs_address == 3'd4) m_rise = avs_writedata[7:0];
      if (avs_write && avs_address == 3'd5) m_fall = avs_writedata[7:0];
      m_cap    = ncap;
      m_stable = nstable;
      for (int k = DB; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = pio_in;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("pio_out", 32'(pio_out), 32'(m_out));
    check("irq", 32'(irq), 32'(m_irq));
    check("readdatavalid", 32'(avs_readdatavalid), 32'(m_rvalid));
    if (m_rvalid || reset) check("readdata", avs_readdata, m_rdata);
  endtask

  task automatic idle(input int n);
    avs_read = 1'b0; avs_write = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1; avs_read = 1'b0;
    cycle();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1; avs_write = 1'b0;
    cycle();
    d = avs_readdata;
    avs_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          hold [0:7];
    int          r;

    reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; pio_in = '0;
    for (int k = 0; k <= DB; k++) hist[k] = '0;
    idle(2);
    check("reset_pio_out", 32'(pio_out), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_readdata", avs_readdata, 32'h0);
    check("reset_rvalid", 32'(avs_readdatavalid), 32'h0);
    reset = 1'b0;
    idle(1);

    // OUT write/readback
    wr(3'd1, 32'h0000_00A5);
    check("out_next_cycle", 32'(pio_out), 32'hA5);
    rd(3'd1, d);
    check("out_readback", d, 32'hA5);
    check("out_readvalid", 32'(avs_readdatavalid), 32'h1);

    // Short glitch must be rejected
    wr(3'd4, 32'h08);
    wr(3'd2, 32'h08);
    pio_in = 8'h08;
    idle(3);
    pio_in = 8'h00;
    idle(8);
    rd(3'd0, d);
    check("glitch_in", d, 32'h0);
    rd(3'd3, d);
    check("glitch_cap", d, 32'h0);
    check("glitch_irq", 32'(irq), 32'h0);

    // Accepted rising edge, latency and irq clear
    pio_in = 8'h08;
    avs_address = 3'd0; avs_read = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      if (i == 6) begin
        check("rise_in_before", avs_readdata, 32'h0);
        check("rise_irq_before", 32'(irq), 32'h0);
      end
      if (i == 7) begin
        check("rise_in_latency", avs_readdata, 32'h08);
        check("rise_irq_set", 32'(irq), 32'h1);
      end
    end
    avs_read = 1'b0;
    rd(3'd3, d);
    check("rise_cap", d, 32'h08);
    wr(3'd3, 32'h08);
    check("irq_still_set", 32'(irq), 32'h1);
    idle(1);
    check("irq_cleared", 32'(irq), 32'h0);

    // Falling edge coincident with a clear: set wins
    do_reset();
    wr(3'd5, 32'h01);
    pio_in = 8'h01;
    idle(8);
    wr(3'd3, 32'hFF);
    pio_in = 8'h00;
    idle(5);
    wr(3'd3, 32'h01);
    idle(1);
    rd(3'd3, d);
    check("set_wins_cap", d, 32'h01);

    // Reset mid-count, then pin held high through release
    do_reset();
    wr(3'd4, 32'h00);
    pio_in = 8'h20;
    idle(3);
    reset = 1'b1;
    avs_address = 3'd0; avs_read = 1'b1;
    cycle();
    check("rst_rvalid", 32'(avs_readdatavalid), 32'h0);
    check("rst_pio_out", 32'(pio_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    cycle();
    check("rst_readdata", avs_readdata, 32'h0);
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      if (i == 6) check("rst_in_before", avs_readdata, 32'h0);
      if (i == 7) check("rst_in_after", avs_readdata, 32'h20);
    end
    avs_read = 1'b0;
    rd(3'd3, d);
    check("rst_cap", d, 32'h0);

    // Back-to-back reads of every address
    for (int i = 0; i < 8; i++) begin
      avs_address = 3'(i); avs_read = 1'b1;
      cycle();
      check("b2b_valid", 32'(avs_readdatavalid), 32'h1);
      if (i >= 6) check("b2b_unmapped", avs_readdata, 32'h0);
    end
    avs_read = 1'b0;

    // Randomized traffic with bouncing pins
    do_reset();
    for (int b = 0; b < 8; b++) hold[b] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 8; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          pio_in[b] = $urandom_range(0, 1) == 1;
          hold[b]   = $urandom_range(1, 9);
        end
      end
      r = $urandom_range(0, 99);
      avs_address   = 3'($urandom_range(0, 7));
      avs_writedata = $urandom;
      avs_read      = (r < 30) || (r >= 55 && r < 62);
      avs_write     = (r >= 30 && r < 62);
      reset         = ($urandom_range(0, 599) == 0);
      cycle();
    end
    reset = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/avmm_pio_edge_irq.md
AVMM_PIO_EDGE_IRQ -- requirements
Module: avmm_pio_edge_irq

Interface
REQ-001 Parameter NUM_CH, default 8: channel count, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept an input change, minimum 1.
REQ-003 clk  in  1  single clock; all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 avs_address  in  3  word address of the register.
REQ-006 avs_read  in  1  read strobe.
REQ-007 avs_write  in  1  write strobe.
REQ-008 avs_writedata  in  32  write data.
REQ-009 avs_readdata  out  32  read data.
REQ-010 avs_readdatavalid  out  1  read data qualifier.
REQ-011 pio_in  in  NUM_CH  asynchronous input pins.
REQ-012 pio_out  out  NUM_CH  registered output pins.
REQ-013 irq  out  1  level interrupt to the HPS.

Function
REQ-014 The register map SHALL be:
- 0 IN: debounced inputs, read-only.
- 1 OUT: drives pio_out, read/write.
- 2 IRQ_MASK: read/write.
- 3 EDGE_CAP: write 1 to clear.
- 4 RISE_EN: read/write.
- 5 FALL_EN: read/write.
- 6, 7: unmapped; reads return 0.
REQ-015 Bits at and above NUM_CH SHALL read 0 and ignore writes.
REQ-016 Writes to IN or to unmapped addresses SHALL be ignored.
REQ-017 There SHALL be no wait states.
REQ-018 Read data SHALL appear with avs_readdatavalid=1 exactly one cycle after avs_read=1; back-to-back reads are allowed.
REQ-019 avs_readdatavalid SHALL be 0 in every other cycle.
REQ-020 If avs_read and avs_write are both 1, the write SHALL take effect and the read SHALL return the value before the write.
REQ-021 Each pio_in bit SHALL pass through a 2-flop synchronizer.
REQ-022 Per channel, a counter of width $clog2(DEBOUNCE_CYCLES+1) SHALL increment each cycle the synchronized value differs from the stable value, and clear when they match.
REQ-023 When a mismatch occurs with the counter at DEBOUNCE_CYCLES-1, the stable value SHALL take the synchronized value and the counter SHALL clear.
REQ-024 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change the stable value.
REQ-025 A stable 0->1 change with the RISE_EN bit set, or a 1->0 change with the FALL_EN bit set, SHALL set the EDGE_CAP bit in the same cycle that the stable value updates.
REQ-026 If an EDGE_CAP clear and a new edge on the same bit occur in the same cycle, the bit SHALL remain 1 (set wins).
REQ-027 irq SHALL be registered and equal |(EDGE_CAP & IRQ_MASK), lagging EDGE_CAP or IRQ_MASK changes by one cycle.
REQ-028 pio_out SHALL update in the cycle after the OUT write.
REQ-029 Pin-to-IN latency SHALL be DEBOUNCE_CYCLES+2 cycles after the first clock edge that samples the new level.

Reset
REQ-030 On reset, all registers, stable values, counters and synchronizers SHALL become 0, so that pio_out=0, irq=0, avs_readdata=0 and avs_readdatavalid=0.
REQ-031 Reset during a debounce count SHALL discard the pending change; pins held high after reset SHALL be accepted after DEBOUNCE_CYCLES+2 cycles with no edge captured unless RISE_EN was written.
REQ-032 A read issued in the reset cycle SHALL produce no avs_readdatavalid.

Structure
REQ-033 A shared package SHALL hold the register-offset constants (IN, OUT, IRQ_MASK, EDGE_CAP, RISE_EN, FALL_EN) and the data width (32).
REQ-034 One sub-module, pio_debounce_ch, SHALL contain the synchronizer, debounce counter and stable-change/direction outputs of one channel, instantiated NUM_CH times via generate.

Verification
All scenarios use NUM_CH=8, DEBOUNCE_CYCLES=4.
REQ-035 Write OUT=0xA5 -> pio_out=0xA5 next cycle; read OUT -> 0xA5 one cycle after the read.
REQ-036 pio_in[3] high for 3 cycles, then low -> IN stays 0x00, EDGE_CAP stays 0x00, irq stays 0.
REQ-037 RISE_EN=0x08, IRQ_MASK=0x08, pio_in[3] held high -> IN=0x08 and EDGE_CAP=0x08 six cycles after first sampling, irq=1 one cycle later; write EDGE_CAP=0x08 -> irq=0 two cycles after the write.
REQ-038 FALL_EN=0x01, stable falling edge on bit 0 coincident with a write of EDGE_CAP=0x01 -> EDGE_CAP[0] stays 1.
REQ-039 Reset asserted mid-count on bit 5 -> all outputs 0 during reset; pin held high -> IN=0x20 six cycles after reset release, EDGE_CAP=0x00.
REQ-040 Back-to-back reads of addresses 0..7 -> 8 consecutive valid cycles; addresses 6 and 7 return 0x00000000.
